// File: rtl/vga_pattern_engine_if.sv
// ----------------------------------------------------------------------------
// vga_pattern_engine_if
//   Bundles the signals between the sync generator / configuration source
//   (master) and the VGA test-pattern engine (slave).
//
//   master drives : hpos, vpos, display_on, mode, fg_index, cfg_scroll,
//                   cfg_cycle, rom_pixel
//   slave drives  : rom_x, rom_y (combinational ROM address),
//                   r, g, b (registered colour), frame_tick (registered pulse)
// ----------------------------------------------------------------------------
interface vga_pattern_engine_if #(
  parameter int COORD_W    = 10,
  parameter int COLOR_BITS = 2,
  parameter int TILE_LOG2  = 7
);
  logic [COORD_W-1:0]    hpos;
  logic [COORD_W-1:0]    vpos;
  logic                  display_on;
  logic [1:0]            mode;
  logic [2:0]            fg_index;
  logic                  cfg_scroll;
  logic                  cfg_cycle;
  logic [TILE_LOG2-1:0]  rom_x;
  logic [TILE_LOG2-1:0]  rom_y;
  logic                  rom_pixel;
  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;
  logic                  frame_tick;

  modport master (
    output hpos, vpos, display_on, mode, fg_index, cfg_scroll, cfg_cycle,
           rom_pixel,
    input  rom_x, rom_y, r, g, b, frame_tick
  );

  modport slave (
    input  hpos, vpos, display_on, mode, fg_index, cfg_scroll, cfg_cycle,
           rom_pixel,
    output rom_x, rom_y, r, g, b, frame_tick
  );
endinterface

// File: rtl/vga_pattern_engine.sv
// ----------------------------------------------------------------------------
// vga_pattern_engine
//   VGA test-pattern generator placed between the sync generator and the
//   PMOD colour mapping. Four patterns (tiled bitmap, single bitmap tile,
//   checkerboard, colour bars), per-frame horizontal scrolling and optional
//   palette colour cycling. Configuration is captured into shadow registers
//   only on the frame tick (hpos==0, vpos==V_TICK, first blanking line), so
//   a frame never tears.
//
//   Ports:
//     clk    - pixel clock
//     reset  - synchronous, active-high
//     bus    - vga_pattern_engine_if.slave:
//                hpos/vpos/display_on   pixel position and active video
//                mode/fg_index          pattern select, foreground palette index
//                cfg_scroll/cfg_cycle   scroll / colour-cycle enables
//                rom_x/rom_y            combinational bitmap ROM address
//                rom_pixel              bitmap bit, same cycle as rom_x/rom_y
//                r/g/b                  registered colour, 1-cycle latency
//                frame_tick             registered 1-cycle pulse per frame
//
//   Build option: define VGA_PATTERN_CYCLE_EN to build colour cycling
//   (div_cnt / color_off). Without it color_off is a constant 0 and
//   cfg_cycle is ignored.
// ----------------------------------------------------------------------------
module vga_pattern_engine #(
  parameter int COORD_W     = 10,
  parameter int COLOR_BITS  = 2,
  parameter int TILE_LOG2   = 7,
  parameter int CHK_LOG2    = 4,
  parameter int BAR_SHIFT   = 6,
  parameter int V_TICK      = 480,
  parameter int SCROLL_STEP = 1,
  parameter int CYCLE_DIV   = 8
) (
  input logic                 clk,
  input logic                 reset,
  vga_pattern_engine_if.slave bus
);

  localparam int DIV_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;

  // Palette: each index bit replicated across one colour channel, packed {r,g,b}.
  function automatic logic [3*COLOR_BITS-1:0] palette(input logic [2:0] idx);
    return {{COLOR_BITS{idx[0]}}, {COLOR_BITS{idx[1]}}, {COLOR_BITS{idx[2]}}};
  endfunction

  // Shadow configuration and per-frame state
  logic [1:0]           sh_mode;
  logic [2:0]           sh_fg;
  logic                 sh_scroll;
  logic [TILE_LOG2-1:0] scroll_x;
  logic [2:0]           color_off;

  // Stage p0: combinational pixel decode from the current position
  logic                 vld_p0;
  logic                 tick_p0;
  logic [TILE_LOG2-1:0] sx_p0;
  logic [2:0]           fg_p0;
  logic                 in_tile_p0;
  logic                 chk_p0;
  logic [2:0]           bar_p0;
  logic [2:0]           idx_p0;

  // Stage p1: registered outputs
  logic [COLOR_BITS-1:0] r_p1;
  logic [COLOR_BITS-1:0] g_p1;
  logic [COLOR_BITS-1:0] b_p1;
  logic                  tick_p1;

  assign vld_p0  = bus.display_on;
  assign tick_p0 = (bus.hpos == '0) && (bus.vpos == COORD_W'(V_TICK));

  // Only the low TILE_LOG2 bits of hpos matter: the sum wraps at the tile edge.
  assign sx_p0      = bus.hpos[TILE_LOG2-1:0] + scroll_x;
  assign bus.rom_x  = sx_p0;
  assign bus.rom_y  = bus.vpos[TILE_LOG2-1:0];

  assign fg_p0      = sh_fg + color_off;
  assign in_tile_p0 = ((bus.hpos >> TILE_LOG2) == '0) &&
                      ((bus.vpos >> TILE_LOG2) == '0);
  assign chk_p0     = sx_p0[CHK_LOG2] ^ bus.vpos[CHK_LOG2];
  // Bars use unscrolled hpos and wrap after 8 bars via the 3-bit truncation.
  assign bar_p0     = 3'(bus.hpos >> BAR_SHIFT) + color_off;

  always_comb begin
    idx_p0 = 3'd0;
    if (vld_p0) begin
      case (sh_mode)
        2'd0:    idx_p0 = bus.rom_pixel ? fg_p0 : 3'd0;
        2'd1:    idx_p0 = (in_tile_p0 && bus.rom_pixel) ? fg_p0 : 3'd0;
        2'd2:    idx_p0 = chk_p0 ? fg_p0 : 3'd0;
        default: idx_p0 = bar_p0;
      endcase
    end
  end

  // Stage p0 -> p1: colour register, tick pulse, shadow/scroll update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1      <= '0;
      g_p1      <= '0;
      b_p1      <= '0;
      tick_p1   <= 1'b0;
      sh_mode   <= 2'd0;
      sh_fg     <= 3'd6;
      sh_scroll <= 1'b0;
      scroll_x  <= '0;
    end else begin
      {r_p1, g_p1, b_p1} <= palette(idx_p0);
      tick_p1            <= tick_p0;
      if (tick_p0) begin
        sh_mode   <= bus.mode;
        sh_fg     <= bus.fg_index;
        sh_scroll <= bus.cfg_scroll;
        // Scroll uses the enable latched on the previous tick.
        if (sh_scroll)
          scroll_x <= scroll_x + TILE_LOG2'(SCROLL_STEP);
      end
    end
  end

`ifdef VGA_PATTERN_CYCLE_EN
  logic             sh_cycle;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_cycle  <= 1'b0;
      div_cnt   <= '0;
      color_off <= 3'd0;
    end else if (tick_p0) begin
      sh_cycle <= bus.cfg_cycle;
      if (sh_cycle) begin
        if (div_cnt == DIV_W'(CYCLE_DIV - 1)) begin
          div_cnt   <= '0;
          color_off <= color_off + 3'd1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end
`else
  logic unused_cfg_cycle;

  assign color_off        = 3'd0;
  assign unused_cfg_cycle = bus.cfg_cycle;
`endif

  assign bus.r          = r_p1;
  assign bus.g          = g_p1;
  assign bus.b          = b_p1;
  assign bus.frame_tick = tick_p1;

endmodule

// File: tb/tb_vga_pattern_engine.sv
module tb_vga_pattern_engine;

  localparam int TILE = 128;
  localparam int VT   = 480;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_pattern_engine_if bus ();

  vga_pattern_engine dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       tick;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int mode; int fg; int h; int v; int d; int p;
    int er; int eg; int eb;
  } vec_t;
  vec_t tv[15];

  // Reference model state (spec-level behaviour)
  int m_mode, m_fg, m_scroll, m_cycle, m_sx, m_div, m_off;

  task automatic model_reset();
    m_mode = 0; m_fg = 6; m_scroll = 0; m_cycle = 0;
    m_sx = 0; m_div = 0; m_off = 0;
  endtask

  function automatic int model_idx(int h, int v, bit d, bit p);
    int sx, fg;
    if (!d) return 0;
    sx = (h + m_sx) % TILE;
    fg = (m_fg + m_off) % 8;
    case (m_mode)
      0: return p ? fg : 0;
      1: return (h < TILE && v < TILE && p) ? fg : 0;
      2: return ((((sx / 16) % 2) ^ ((v / 16) % 2)) != 0) ? fg : 0;
      default: return ((h / 64) + m_off) % 8;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel clock: drive, check ROM address, predict, clock, compare.
  task automatic cyc(int h, int v, bit d, bit p);
    exp_t e;
    int idx;
    bus.hpos = 10'(h);
    bus.vpos = 10'(v);
    bus.display_on = d;
    bus.rom_pixel = p;
    #2;
    chk("rom_x", 32'(bus.rom_x), 32'((h + m_sx) % TILE));
    chk("rom_y", 32'(bus.rom_y), 32'(v % TILE));
    if (rst) begin
      e = '{2'd0, 2'd0, 2'd0, 1'b0};
      model_reset();
    end else begin
      idx = model_idx(h, v, d, p);
      e.r = idx[0] ? 2'd3 : 2'd0;
      e.g = idx[1] ? 2'd3 : 2'd0;
      e.b = idx[2] ? 2'd3 : 2'd0;
      e.tick = (h == 0 && v == VT);
      if (e.tick) begin
        if (m_scroll != 0) m_sx = (m_sx + 1) % TILE;
`ifdef VGA_PATTERN_CYCLE_EN
        if (m_cycle != 0) begin
          if (m_div == 7) begin
            m_div = 0;
            m_off = (m_off + 1) % 8;
          end else begin
            m_div++;
          end
        end
`endif
        m_mode = int'(bus.mode); m_fg = int'(bus.fg_index);
        m_scroll = int'(bus.cfg_scroll); m_cycle = int'(bus.cfg_cycle);
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = q.pop_front();
      chk("r", 32'(bus.r), 32'(e.r));
      chk("g", 32'(bus.g), 32'(e.g));
      chk("b", 32'(bus.b), 32'(e.b));
      chk("frame_tick", 32'(bus.frame_tick), 32'(e.tick));
    end
  endtask

  task automatic set_cfg(int mode, int fg, bit sc, bit cy);
    bus.mode = 2'(mode); bus.fg_index = 3'(fg);
    bus.cfg_scroll = sc; bus.cfg_cycle = cy;
  endtask

  initial begin
    tv[0]  = '{0, 6, 100,  50, 1, 1, 0, 3, 3};
    tv[1]  = '{0, 6, 100,  50, 1, 0, 0, 0, 0};
    tv[2]  = '{0, 5,  10,  10, 1, 1, 3, 0, 3};
    tv[3]  = '{1, 7, 127, 127, 1, 1, 3, 3, 3};
    tv[4]  = '{1, 7, 128,   5, 1, 1, 0, 0, 0};
    tv[5]  = '{1, 7,   5, 128, 1, 1, 0, 0, 0};
    tv[6]  = '{2, 3,  16,   0, 1, 0, 3, 3, 0};
    tv[7]  = '{2, 3,  16,  16, 1, 1, 0, 0, 0};
    tv[8]  = '{2, 3,   0,  16, 1, 0, 3, 3, 0};
    tv[9]  = '{2, 3,  16,   0, 0, 1, 0, 0, 0};
    tv[10] = '{3, 0, 130,   0, 1, 0, 0, 3, 0};
    tv[11] = '{3, 0,   0,   0, 1, 1, 0, 0, 0};
    tv[12] = '{3, 0, 448,   0, 1, 0, 3, 3, 3};
    tv[13] = '{3, 0, 512,   0, 1, 1, 0, 0, 0};
    tv[14] = '{3, 0, 639,   0, 1, 0, 3, 0, 0};

    model_reset();
    set_cfg(0, 6, 0, 0);
    bus.hpos = '0; bus.vpos = '0; bus.display_on = 1'b0; bus.rom_pixel = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held 3 cycles mid-line with active video and a set bitmap bit
    for (int i = 0; i < 3; i++) cyc(300 + i, 100, 1, 1);
    chk("reset_rgb", 32'({bus.r, bus.g, bus.b}), 32'd0);
    chk("reset_tick", 32'(bus.frame_tick), 32'd0);
    rst = 1'b0;
    cyc(303, 100, 1, 1);
    chk("post_reset_r", 32'(bus.r), 32'd0);
    chk("post_reset_g", 32'(bus.g), 32'd3);
    chk("post_reset_b", 32'(bus.b), 32'd3);

    // Table vectors: latch config on a tick, then apply one pixel
    for (int i = 0; i < 15; i++) begin
      set_cfg(tv[i].mode, tv[i].fg, 0, 0);
      cyc(0, VT, 0, 0);
      cyc(tv[i].h, tv[i].v, tv[i].d[0], tv[i].p[0]);
      chk("tbl_r", 32'(bus.r), 32'(tv[i].er));
      chk("tbl_g", 32'(bus.g), 32'(tv[i].eg));
      chk("tbl_b", 32'(bus.b), 32'(tv[i].eb));
    end

    // Config latching: mode change mid-frame is invisible until the tick
    set_cfg(0, 6, 0, 0);
    cyc(0, VT, 0, 0);
    bus.mode = 2'd3;
    cyc(100, 200, 1, 1);
    chk("latch_hold_g", 32'(bus.g), 32'd3);
    chk("latch_hold_r", 32'(bus.r), 32'd0);
    cyc(130, 200, 1, 0);
    chk("latch_hold_blk", 32'({bus.r, bus.g, bus.b}), 32'd0);
    cyc(0, VT, 0, 0);
    chk("latch_tick", 32'(bus.frame_tick), 32'd1);
    cyc(130, 10, 1, 0);
    chk("latch_new_rgb", 32'({bus.r, bus.g, bus.b}), 32'b00_11_00);
    chk("tick_one_cycle", 32'(bus.frame_tick), 32'd0);

    // Reset coinciding with the tick: reset wins, no advance, no pulse
    set_cfg(0, 6, 1, 1);
    cyc(0, VT, 0, 0);
    cyc(0, VT, 0, 0);
    rst = 1'b1;
    cyc(0, VT, 0, 0);
    chk("rst_tick_pulse", 32'(bus.frame_tick), 32'd0);
    rst = 1'b0;
    cyc(5, 10, 1, 1);
    chk("rst_tick_romx", 32'(bus.rom_x), 32'd5);
    chk("rst_tick_fg", 32'({bus.r, bus.g, bus.b}), 32'b00_11_11);

    // Scrolling: latch enable, then 130 ticks -> offset 2
    set_cfg(0, 6, 1, 0);
    cyc(0, VT, 0, 0);
    for (int i = 0; i < 130; i++) cyc(0, VT, 0, 0);
    bus.cfg_scroll = 1'b0;
    cyc(5, 10, 1, 1);
    chk("scroll_romx", 32'(bus.rom_x), 32'd7);

    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
`ifdef VGA_PATTERN_CYCLE_EN
    // Colour cycling: fg 7, one step every 8 enabled ticks
    set_cfg(0, 7, 0, 1);
    cyc(0, VT, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, VT, 0, 0);
    cyc(10, 10, 1, 1);
    chk("cycle8_rgb", 32'({bus.r, bus.g, bus.b}), 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, VT, 0, 0);
    cyc(10, 10, 1, 1);
    chk("cycle16_rgb", 32'({bus.r, bus.g, bus.b}), 32'b11_00_00);
`else
    // Without cycling: bars stay static, fg stays as configured
    set_cfg(3, 7, 0, 1);
    cyc(0, VT, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, VT, 0, 0);
    cyc(0, 10, 1, 0);
    chk("static_bar0", 32'({bus.r, bus.g, bus.b}), 32'd0);
    cyc(64, 10, 1, 0);
    chk("static_bar1", 32'({bus.r, bus.g, bus.b}), 32'b11_00_00);
    set_cfg(0, 7, 0, 1);
    cyc(0, VT, 0, 0);
    cyc(10, 10, 1, 1);
    chk("static_fg", 32'({bus.r, bus.g, bus.b}), 32'b11_11_11);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        cyc(0, VT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        cyc($urandom_range(0, 799), $urandom_range(0, 524),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_engine.md
# vga_pattern_engine

Parametrised VGA test-pattern engine that sits between `vga_sync_generator` and the TinyVGA PMOD output mapping in the top level. It replaces the fixed "bitmap ROM × one palette colour" path with four selectable patterns, per-frame horizontal scrolling and palette colour cycling. Configuration inputs are latched only during vertical blanking, so a frame never tears. It drives an external bitmap ROM through a combinational address/data port and outputs registered RGB.

## Interface
Parameters:
- `COORD_W`, 10: width of `hpos`/`vpos`.
- `COLOR_BITS`, 2: bits per colour channel.
- `TILE_LOG2`, 7: log2 of the bitmap tile edge; ROM address width per axis.
- `CHK_LOG2`, 4: log2 of the checkerboard square edge.
- `BAR_SHIFT`, 6: colour-bar width is 2^BAR_SHIFT pixels.
- `V_TICK`, 480: `vpos` line on which the frame tick fires (first blanking line).
- `SCROLL_STEP`, 1: pixels added to the scroll offset per frame.
- `CYCLE_DIV`, 8: frames per colour-cycle step, ≥1.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high reset.
- `hpos` in COORD_W: current pixel x from the sync generator.
- `vpos` in COORD_W: current pixel y.
- `display_on` in 1: active video.
- `mode` in 2: 0 tiled bitmap, 1 single bitmap tile, 2 checkerboard, 3 colour bars.
- `fg_index` in 3: foreground palette index.
- `cfg_scroll` in 1: enable horizontal scroll.
- `cfg_cycle` in 1: enable colour cycling.
- `rom_x` out TILE_LOG2: bitmap column, combinational.
- `rom_y` out TILE_LOG2: bitmap row, combinational.
- `rom_pixel` in 1: bitmap bit for (`rom_x`,`rom_y`), same cycle.
- `r`, `g`, `b` out COLOR_BITS each: registered colour.
- `frame_tick` out 1: registered one-cycle pulse per frame.

## Operation
- **Palette.** Index i maps to R = {COLOR_BITS{i[0]}}, G = {COLOR_BITS{i[1]}}, B = {COLOR_BITS{i[2]}}. Index 0 is black.
- **Tick condition.** `hpos==0 && vpos==V_TICK`. On the edge ending that cycle:
  - shadow registers load `mode`, `fg_index`, `cfg_scroll`, `cfg_cycle`;
  - if the old shadow scroll is 1, `scroll_x` += SCROLL_STEP, mod 2^TILE_LOG2;
  - if the old shadow cycle is 1, `div_cnt` counts 0..CYCLE_DIV-1. On wrap it returns to 0 and `color_off` += 1 mod 8.
  - If the old shadow cycle is 0, `div_cnt` and `color_off` hold.
- **Effective indices.**
  - `sx` = (hpos + scroll_x) mod 2^TILE_LOG2.
  - `rom_x` = `sx`.
  - `rom_y` = vpos[TILE_LOG2-1:0].
  - fg = (shadow fg_index + color_off) mod 8.
- **Patterns** (shadow mode):
  - Mode 0: fg if `rom_pixel`, else 0.
  - Mode 1: as mode 0 only when hpos>>TILE_LOG2==0 and vpos>>TILE_LOG2==0; 0 elsewhere. Scroll still applies to `sx`.
  - Mode 2: fg if (`sx`>>CHK_LOG2)[0] XOR (vpos>>CHK_LOG2)[0], else 0.
  - Mode 3: index ((hpos>>BAR_SHIFT) + color_off) mod 8. Scroll is ignored; bars wrap every 8 bars.
- **Blanking.** `display_on`==0 selects index 0.
- **Reset state.**
  - Shadow registers: mode 0, fg 3'd6, scroll 0, cycle 0.
  - `scroll_x` 0, `div_cnt` 0, `color_off` 0.
  - `r`/`g`/`b` 0, `frame_tick` 0.
  - Reset mid-frame clears everything on that edge. The next tick occurs at the next (0,V_TICK).

## Timing
- Latency is 1 cycle: `r`/`g`/`b` at edge N+1 reflect `hpos`/`vpos`/`display_on`/`rom_pixel` of cycle N.
- `rom_x`/`rom_y` are purely combinational from `hpos`/`vpos`/`scroll_x`. The ROM must respond in the same cycle.
- `frame_tick` is high the cycle after the tick condition, for exactly one cycle.
- Config changes take effect from the first active pixel after the next tick. Changes between ticks have no visible effect.
- Simultaneous `reset` and tick condition: reset wins; no counter advances.
- `scroll_x` and `color_off` wrap silently. CYCLE_DIV=1 advances `color_off` every enabled tick.

## Configuration
- Macro: `VGA_PATTERN_CYCLE_EN`.
- **Defined:** colour cycling as described above.
- **Undefined:**
  - `div_cnt` and `color_off` are not built; `color_off` is constant 0.
  - `cfg_cycle` is ignored.
  - Mode 3 bars are static and fg equals shadow `fg_index`.
  - All other behaviour is unchanged.

## Test plan
- **Reset.** Hold `reset` 3 cycles mid-line with `display_on`=1 and `rom_pixel`=1 -> `r`/`g`/`b`=0 and `frame_tick`=0 during reset. The first pixel after release, in mode 0 with `rom_pixel`=1, is fg 6 -> r=0, g=3, b=3.
- **Config latching.** Set mode=3 at (100,200) -> output stays mode 0 until after tick (0,480). Next frame at hpos=130 -> index 2 -> g=3, r=b=0.
- **Scrolling.** cfg_scroll=1, SCROLL_STEP=1 for 130 ticks -> `scroll_x` = 130 mod 128 = 2. At hpos=5, `rom_x`=7.
- **Colour cycling** (macro defined). cfg_cycle=1, CYCLE_DIV=8, fg_index=7:
  - 8 ticks -> `color_off`=1, fg=0, mode 0 outputs black;
  - 16 ticks -> fg=1, r=3.
- **Checkerboard and blanking.** Mode 2, scroll 0: (16,0) -> fg; (16,16) -> 0; `display_on`=0 -> 0.
- **Macro undefined.** cfg_cycle=1 for 64 ticks -> mode 3 bar at hpos=0 stays index 0, black.
